// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dram_pkg
// Purpose  : Shared definitions for the DRAM command scheduler, its bank
//            table, the DRAM behavioural model and the bench: scheduler
//            state encoding, bank-table lookup result, default timing values
//            and address-field width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package dram_pkg;

    // Default timing, in clock cycles
    localparam int c_T_RP_DEF   = 2;
    localparam int c_T_RCD_DEF  = 2;
    localparam int c_T_REFI_DEF = 64;

    // Scheduler states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ACT  = 3'd2,
        ST_ACC  = 3'd3,
        ST_RDW  = 3'd4,
        ST_REF  = 3'd5
    } state_t;

    // Open-row table lookup result
    localparam logic [1:0] LK_CLOSED   = 2'd0;
    localparam logic [1:0] LK_HIT      = 2'd1;
    localparam logic [1:0] LK_CONFLICT = 2'd2;

    // Width of an index over n items; never narrower than one bit
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bank_width(input int n_banks);
        return addr_width(n_banks);
    endfunction

    function automatic int row_width(input int n_rows);
        return addr_width(n_rows);
    endfunction

    function automatic int col_width(input int n_cols);
        return addr_width(n_cols);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_bank_table.sv
`default_nettype none
// ============================================================================
// Module   : dram_bank_table
// Purpose  : Open-row bookkeeping, one valid bit and one row per bank.
//            Combinational lookup classifies an address as hit / closed /
//            conflict. Clear (single bank or all) wins over set.
// Ports    : clk, rst_b          clock, async active-low reset
//            i_lk_bank/i_lk_row  lookup address
//            o_lk                LK_HIT / LK_CLOSED / LK_CONFLICT
//            i_set_en/bank/row   mark bank open on row
//            i_clr_en/bank       mark one bank closed
//            i_clr_all           mark every bank closed
// Revision : 1.0 - initial release
// ============================================================================
module dram_bank_table
    import dram_pkg::*;
#(
    parameter int  NUM_OF_BANKS = 8,
    parameter int  NUM_OF_ROWS  = 128,
    localparam int c_BANK_W     = bank_width(NUM_OF_BANKS),
    localparam int c_ROW_W      = row_width(NUM_OF_ROWS)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [c_BANK_W-1:0] i_lk_bank,
    input  logic [c_ROW_W-1:0]  i_lk_row,
    output logic [1:0]          o_lk,
    input  logic                i_set_en,
    input  logic [c_BANK_W-1:0] i_set_bank,
    input  logic [c_ROW_W-1:0]  i_set_row,
    input  logic                i_clr_en,
    input  logic [c_BANK_W-1:0] i_clr_bank,
    input  logic                i_clr_all
);

    logic [NUM_OF_BANKS-1:0] r_open_valid;
    logic [c_ROW_W-1:0]      r_open_row [NUM_OF_BANKS];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_open_valid <= '0;
            for (int b = 0; b < NUM_OF_BANKS; b++) begin
                r_open_row[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_OF_BANKS; b++) begin
                if (i_clr_all || (i_clr_en && (i_clr_bank == c_BANK_W'(b)))) begin
                    r_open_valid[b] <= 1'b0;
                end else if (i_set_en && (i_set_bank == c_BANK_W'(b))) begin
                    r_open_valid[b] <= 1'b1;
                    r_open_row[b]   <= i_set_row;
                end
            end
        end
    end

    always_comb begin
        o_lk = LK_CLOSED;
        if (r_open_valid[i_lk_bank]) begin
            o_lk = (r_open_row[i_lk_bank] == i_lk_row) ? LK_HIT : LK_CONFLICT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dram_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_sched
// Purpose  : Single-requester DRAM command scheduler. Accepts one read or
//            write at a time, sequences precharge / activate / access with
//            programmable delays against a per-bank open-row table, and
//            inserts a refresh every T_REFI cycles.
// Ports    : clk, rst_b                   clock, async active-low reset
//            req_valid/req_ready          request handshake
//            req_rw, req_bank/row/col     request (1 = write), address
//            req_wdata                    write data
//            rsp_valid, rsp_rdata         one-cycle read response
//            mem_bankid/rowid/colid       memory address pins
//            mem_rw, mem_din              memory write strobe and data
//            mem_dout                     memory read data (1-cycle latency)
//            busy                         scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module dram_cmd_sched
    import dram_pkg::*;
#(
    parameter int  NUM_OF_BANKS = 8,
    parameter int  NUM_OF_ROWS  = 128,
    parameter int  NUM_OF_COLS  = 8,
    parameter int  DATA_WIDTH   = 1,
    parameter int  T_RP         = c_T_RP_DEF,
    parameter int  T_RCD        = c_T_RCD_DEF,
    parameter int  T_REFI       = c_T_REFI_DEF,
    localparam int c_BANK_W     = bank_width(NUM_OF_BANKS),
    localparam int c_ROW_W      = row_width(NUM_OF_ROWS),
    localparam int c_COL_W      = col_width(NUM_OF_COLS)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [c_BANK_W-1:0]   req_bank,
    input  logic [c_ROW_W-1:0]    req_row,
    input  logic [c_COL_W-1:0]    req_col,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [c_BANK_W-1:0]   mem_bankid,
    output logic [c_ROW_W-1:0]    mem_rowid,
    output logic [c_COL_W-1:0]    mem_colid,
    output logic                  mem_rw,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy
);

    localparam int c_DLY_MAX  = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int c_DLY_W    = addr_width(c_DLY_MAX + 1);
    localparam int c_REFI_W   = addr_width(T_REFI);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_DLY_W-1:0]    r_dly;
    logic [c_REFI_W-1:0]   r_refi;
    logic                  r_ref_pend;
    logic                  w_refi_wrap;
    logic                  w_ref_take;
    logic                  w_hs;
    logic [1:0]            w_lk;
    logic                  w_set_open;

    // Latched request; these also drive the memory address pins, so the
    // pins naturally hold their last value while idle.
    logic                  r_rw;
    logic [c_BANK_W-1:0]   r_bank;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_COL_W-1:0]    r_col;
    logic [DATA_WIDTH-1:0] r_wdata;

    // Gated with rst_b so ready reads low while reset is held.
    assign req_ready   = rst_b && (r_state == ST_IDLE) && !r_ref_pend;
    assign w_hs        = req_valid && req_ready;
    assign w_refi_wrap = (r_refi == c_REFI_W'(T_REFI - 1));
    assign w_set_open  = (r_state == ST_ACT) && (w_state_nxt == ST_ACC);

    dram_bank_table #(
        .NUM_OF_BANKS (NUM_OF_BANKS),
        .NUM_OF_ROWS  (NUM_OF_ROWS)
    ) u_bank_table (
        .clk        (clk),
        .rst_b      (rst_b),
        .i_lk_bank  (req_bank),
        .i_lk_row   (req_row),
        .o_lk       (w_lk),
        .i_set_en   (w_set_open),
        .i_set_bank (r_bank),
        .i_set_row  (r_row),
        .i_clr_en   (r_state == ST_PRE),
        .i_clr_bank (r_bank),
        .i_clr_all  (r_state == ST_REF)
    );

    // State register; the delay counter restarts on every state change so
    // PRE/ACT/REF each see 0..T-1 from entry.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
            r_dly   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= (w_state_nxt != r_state) ? '0 : r_dly + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ref_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ref_pend) begin
                    w_state_nxt = ST_REF;
                    w_ref_take  = 1'b1;
                end else if (req_valid) begin
                    case (w_lk)
                        LK_HIT:      w_state_nxt = ST_ACC;
                        LK_CONFLICT: w_state_nxt = ST_PRE;
                        default:     w_state_nxt = ST_ACT;
                    endcase
                end
            end
            ST_PRE: if (r_dly == c_DLY_W'(T_RP - 1))  w_state_nxt = ST_ACT;
            ST_ACT: if (r_dly == c_DLY_W'(T_RCD - 1)) w_state_nxt = ST_ACC;
            ST_ACC: w_state_nxt = r_rw ? ST_IDLE : ST_RDW;
            ST_RDW: w_state_nxt = ST_IDLE;
            ST_REF: if (r_dly == c_DLY_W'(T_RP - 1))  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Free-running refresh interval counter. An expiry while a refresh is
    // already pending just leaves the flag set; expiry beats the clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_refi     <= '0;
            r_ref_pend <= 1'b0;
        end else begin
            r_refi <= w_refi_wrap ? '0 : r_refi + 1'b1;
            if (w_refi_wrap) begin
                r_ref_pend <= 1'b1;
            end else if (w_ref_take) begin
                r_ref_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rw    <= 1'b0;
            r_bank  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_wdata <= '0;
        end else if (w_hs) begin
            r_rw    <= req_rw;
            r_bank  <= req_bank;
            r_row   <= req_row;
            r_col   <= req_col;
            r_wdata <= req_wdata;
        end
    end

    assign mem_bankid = r_bank;
    assign mem_rowid  = r_row;
    assign mem_colid  = r_col;
    assign mem_din    = r_wdata;
    assign mem_rw     = (r_state == ST_ACC) && r_rw;
    assign rsp_valid  = (r_state == ST_RDW);
    assign rsp_rdata  = rsp_valid ? mem_dout : '0;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
